// File: rtl/cpu16_disp_pkg.sv
// Shared display-path package: converter FSM encoding and datapath sizes.
// Also used by the 7-segment stage.
package cpu16_disp_pkg;

    localparam int BIN_W       = 16;
    localparam int BCD_DIGITS  = 5;
    localparam int BCD_W       = BCD_DIGITS * 4;
    localparam int SHIFT_CNT_W = 5;

    // Converter FSM encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Counter value seen during the final (16th) shift cycle
    localparam logic [SHIFT_CNT_W-1:0] LAST_SHIFT = SHIFT_CNT_W'(BIN_W - 1);
    localparam logic [SHIFT_CNT_W-1:0] CNT_ONE    = SHIFT_CNT_W'(1);

    typedef logic [BCD_W-1:0] bcd_word_t;

    // Leading-zero mask: bit i set when digits BCD_DIGITS-1..i are all zero.
    // Digit 0 is never blanked so a zero value still shows "0".
    function automatic logic [BCD_DIGITS-1:0] lz_blank(input bcd_word_t bcd);
        logic [BCD_DIGITS-1:0] mask;
        logic                  all_zero;
        mask     = '0;
        all_zero = 1'b1;
        for (int i = BCD_DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero & (bcd[i*4 +: 4] == 4'd0);
            mask[i]  = all_zero;
        end
        return mask;
    endfunction

endpackage

// File: rtl/bin16_bcd_seq_if.sv
// Handshake and result bus of the binary-to-BCD converter.
// master = producer of values / consumer of results; slave = converter.
interface bin16_bcd_seq_if;
    import cpu16_disp_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [BIN_W-1:0]      bin_in;
    logic                  out_valid;
    logic                  negative;
    logic [3:0]            bcd_digit0;
    logic [3:0]            bcd_digit1;
    logic [3:0]            bcd_digit2;
    logic [3:0]            bcd_digit3;
    logic [3:0]            bcd_digit4;
    logic [BCD_DIGITS-1:0] blank;

    modport slave (
        input  in_valid, bin_in,
        output in_ready, out_valid, negative,
        output bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4,
        output blank
    );

    modport master (
        output in_valid, bin_in,
        input  in_ready, out_valid, negative,
        input  bcd_digit0, bcd_digit1, bcd_digit2, bcd_digit3, bcd_digit4,
        input  blank
    );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Conditional +3 correction
    always_comb begin
        dout = (din >= 4'd5) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/bin16_bcd_seq.sv
// Sequential signed 16-bit binary to 5-digit BCD converter (shift/add-3).
// One conversion takes 18 cycles: accept, 16 shifts, result register.
// Optional feature macro: LEADING_ZERO_BLANK_EN (registered leading-zero
// blank mask; when undefined the blank output is tied to zero).
module bin16_bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic            clk,
    input  logic            KEY,
    bin16_bcd_seq_if.slave  bus
);
    import cpu16_disp_pkg::*;

    localparam int SCR_W = DIGITS * 4;
    localparam logic [WIDTH-1:0] MAG_ONE = WIDTH'(1);

    logic [1:0]             state_q, state_d;
    logic [SHIFT_CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]       mag_q, mag_d;
    logic [SCR_W-1:0]       scratch_q, scratch_d;
    logic [SCR_W-1:0]       scratch_adj;
    logic                   neg_q, neg_d;
    logic [SCR_W-1:0]       bcd_q, bcd_d;
    logic                   negative_q, negative_d;
    logic                   out_valid_q, out_valid_d;

    // One add-3 corrector per digit of the scratch register
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch_q[gi*4 +: 4]),
            .dout (scratch_adj[gi*4 +: 4])
        );
    end

    // FSM next state and datapath updates
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mag_d       = mag_q;
        scratch_d   = scratch_q;
        neg_d       = neg_q;
        bcd_d       = bcd_q;
        negative_d  = negative_q;
        out_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    neg_d     = bus.bin_in[WIDTH-1];
                    // -32768 negates to itself, which is 0x8000 unsigned
                    mag_d     = bus.bin_in[WIDTH-1] ? ((~bus.bin_in) + MAG_ONE)
                                                    : bus.bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, mag_d} = {scratch_adj, mag_q} << 1;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == LAST_SHIFT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d       = scratch_q;
                negative_d  = neg_q;
                out_valid_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, scratch and result registers
    always_ff @(posedge clk or negedge KEY) begin
        if (!KEY) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mag_q       <= '0;
            scratch_q   <= '0;
            neg_q       <= 1'b0;
            bcd_q       <= '0;
            negative_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mag_q       <= mag_d;
            scratch_q   <= scratch_d;
            neg_q       <= neg_d;
            bcd_q       <= bcd_d;
            negative_q  <= negative_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_q, blank_d;

    // Blank mask captured alongside the digits
    always_comb begin
        blank_d = blank_q;
        if (state_q == ST_DONE) begin
            blank_d = lz_blank(scratch_q);
        end
    end

    // Blank mask register
    always_ff @(posedge clk or negedge KEY) begin
        if (!KEY) begin
            blank_q <= '0;
        end else begin
            blank_q <= blank_d;
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.negative   = negative_q;
    assign bus.bcd_digit0 = bcd_q[3:0];
    assign bus.bcd_digit1 = bcd_q[7:4];
    assign bus.bcd_digit2 = bcd_q[11:8];
    assign bus.bcd_digit3 = bcd_q[15:12];
    assign bus.bcd_digit4 = bcd_q[19:16];

endmodule

// File: tb/tb_bin16_bcd_seq.sv
// Testbench for bin16_bcd_seq: directed vector table, handshake/reset
// sequences and randomized values against an arithmetic reference model.
module tb_bin16_bcd_seq;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB_EN = 1'b1;
`else
    localparam bit LZB_EN = 1'b0;
`endif

    logic clk;
    logic key_n;

    bin16_bcd_seq_if bus ();

    bin16_bcd_seq dut (
        .clk (clk),
        .KEY (key_n),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] value;
        logic        neg;
        logic [19:0] bcd;
        logic [4:0]  blank;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] dut_bcd();
        return {bus.bcd_digit4, bus.bcd_digit3, bus.bcd_digit2,
                bus.bcd_digit1, bus.bcd_digit0};
    endfunction

    // Reference: sign and decimal digits from plain integer arithmetic
    task automatic model(input logic [15:0] v, output logic neg,
                         output logic [19:0] bcd, output logic [4:0] blank);
        shortint s;
        int      mag;
        int      p;
        s     = shortint'(v);
        neg   = (s < 0);
        mag   = (s < 0) ? -int'(s) : int'(s);
        bcd   = '0;
        blank = '0;
        p     = 1;
        for (int i = 0; i < 5; i++) begin
            bcd[i*4 +: 4] = 4'((mag / p) % 10);
            if (LZB_EN && i > 0 && mag < p) blank[i] = 1'b1;
            p = p * 10;
        end
    endtask

    // Present one value, return cycles waited for in_ready and the
    // number of edges from acceptance to the out_valid pulse
    task automatic convert(input logic [15:0] v, output int waited, output int lat);
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 40) begin
            @(posedge clk); #1;
            waited++;
        end
        bus.bin_in   = v;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] v,
                                input logic neg, input logic [19:0] bcd,
                                input logic [4:0] blank, input int lat);
        $display("[TB] %s in=%h lat=%0d neg=%b digits=%h blank=%b", tag, v, lat,
                 bus.negative, dut_bcd(), bus.blank);
        chk({tag, " latency"}, 32'(lat), 32'd17);
        chk({tag, " negative"}, 32'(bus.negative), 32'(neg));
        chk({tag, " digits"}, 32'(dut_bcd()), 32'(bcd));
        chk({tag, " blank"}, 32'(bus.blank), 32'(blank));
    endtask

    initial begin
        int          waited;
        int          lat;
        int          pulses;
        logic        m_neg;
        logic [19:0] m_bcd;
        logic [4:0]  m_blank;
        logic [15:0] rv;

        vecs[0]  = '{16'd12345, 1'b0, 20'h12345, 5'b00000};
        vecs[1]  = '{16'hFFFF,  1'b1, 20'h00001, 5'b11110};
        vecs[2]  = '{16'h8000,  1'b1, 20'h32768, 5'b00000};
        vecs[3]  = '{16'd0,     1'b0, 20'h00000, 5'b11110};
        vecs[4]  = '{16'd99,    1'b0, 20'h00099, 5'b11100};
        vecs[5]  = '{16'd42,    1'b0, 20'h00042, 5'b11100};
        vecs[6]  = '{16'h7FFF,  1'b0, 20'h32767, 5'b00000};
        vecs[7]  = '{16'd10000, 1'b0, 20'h10000, 5'b00000};
        vecs[8]  = '{16'd9,     1'b0, 20'h00009, 5'b11110};
        vecs[9]  = '{16'd10,    1'b0, 20'h00010, 5'b11100};
        vecs[10] = '{16'hFF9C,  1'b1, 20'h00100, 5'b11000};

        key_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.bin_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset negative", 32'(bus.negative), 32'd0);
        chk("reset digits", 32'(dut_bcd()), 32'd0);
        chk("reset blank", 32'(bus.blank), 32'd0);
        key_n = 1'b1;
        @(posedge clk); #1;

        // Directed table, back-to-back: every accept after the first must
        // land on the edge right after the out_valid edge
        for (int i = 0; i < 11; i++) begin
            convert(vecs[i].value, waited, lat);
            check_result($sformatf("vec%0d", i), vecs[i].value, vecs[i].neg,
                         vecs[i].bcd, LZB_EN ? vecs[i].blank : 5'b00000, lat);
            chk($sformatf("vec%0d ready wait", i), 32'(waited), 32'd0);
        end

        // out_valid is a single-cycle pulse and results hold afterwards
        @(posedge clk); #1;
        chk("pulse width", 32'(bus.out_valid), 32'd0);
        chk("hold digits", 32'(dut_bcd()), 32'h00100);
        chk("hold negative", 32'(bus.negative), 32'd1);

        // Input presented during SHIFT is ignored
        convert(16'd12345, waited, lat);
        check_result("prior", 16'd12345, 1'b0, 20'h12345, 5'b00000, lat);
        bus.bin_in   = 16'd4321;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.bin_in = 16'd777;
        lat = 0;
        for (int c = 0; c < 10; c++) begin
            chk($sformatf("busy in_ready c%0d", c), 32'(bus.in_ready), 32'd0);
            chk($sformatf("busy digits c%0d", c), 32'(dut_bcd()), 32'h12345);
            @(posedge clk); #1;
            lat++;
        end
        bus.in_valid = 1'b0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_result("busy", 16'd4321, 1'b0, 20'h04321, LZB_EN ? 5'b10000 : 5'b00000, lat);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        chk("no extra conversion", 32'(pulses), 32'd0);
        chk("idle hold digits", 32'(dut_bcd()), 32'h04321);

        // Reset in the middle of a conversion
        convert(16'h8000, waited, lat);
        check_result("pre-reset", 16'h8000, 1'b1, 20'h32768, 5'b00000, lat);
        bus.bin_in   = 16'd31000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        key_n = 1'b0;
        #1;
        chk("midreset negative", 32'(bus.negative), 32'd0);
        chk("midreset digits", 32'(dut_bcd()), 32'd0);
        chk("midreset out_valid", 32'(bus.out_valid), 32'd0);
        chk("midreset in_ready", 32'(bus.in_ready), 32'd1);
        chk("midreset blank", 32'(bus.blank), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        key_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        chk("aborted no out_valid", 32'(pulses), 32'd0);
        chk("aborted digits", 32'(dut_bcd()), 32'd0);
        convert(16'd500, waited, lat);
        check_result("post-reset", 16'd500, 1'b0, 20'h00500, LZB_EN ? 5'b11000 : 5'b00000, lat);

        // Randomized values against the arithmetic model
        for (int n = 0; n < 200; n++) begin
            rv = 16'($urandom);
            if (n % 17 == 0) rv = 16'($urandom_range(0, 20));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            model(rv, m_neg, m_bcd, m_blank);
            convert(rv, waited, lat);
            check_result($sformatf("rand%0d", n), rv, m_neg, m_bcd, m_blank, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
